uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Bus-side view of the UART receiver: show-ahead FIFO read port and error pulses.
interface uart_rx_if;
    logic       rd_en;
    logic [7:0] data;
    logic       state;
    logic       frame_err;
    logic       overrun;

    modport master (output rd_en, input data, state, frame_err, overrun);
    modport slave  (input rd_en, output data, state, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: RXD synchroniser, start detect, baud-tick sampling FSM
// and a show-ahead byte FIFO for the bus side.
module uart_rx #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic      clk,
    input  logic      RSTn,
    input  logic      RXD,
    input  logic      clk_uart,
    output logic      bps_en,
    uart_rx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic        rx_s1_q, rx_s2_q, rx_h_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        tick, stop_tick, start_edge, empty, full, push, pop;

    // Synchroniser and history flops idle high like the line itself.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_h_q  <= 1'b1;
        end else begin
            rx_s1_q <= RXD;
            rx_s2_q <= rx_s1_q;
            rx_h_q  <= rx_s2_q;
        end
    end

    assign start_edge = rx_h_q & ~rx_s2_q;
    assign tick       = clk_uart & (fsm_q != IDLE);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            fsm_q     <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            fsm_q     <= fsm_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        unique case (fsm_q)
            IDLE:  if (start_edge) fsm_d = START;
            START: if (tick) begin
                if (rx_s2_q) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d     = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA:  if (tick) begin
                shift_d   = {rx_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) fsm_d = STOP;
            end
            STOP:  if (tick) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // A full FIFO still accepts the byte when the bus pops in the same cycle.
    always_comb begin
        bps_en      = (fsm_q != IDLE);
        stop_tick   = tick & (fsm_q == STOP);
        push        = stop_tick & rx_s2_q & (~full | bus.rd_en);
        pop         = bus.rd_en & ~empty;
        frame_err_d = stop_tick & ~rx_s2_q;
        overrun_d   = stop_tick & rx_s2_q & full & ~bus.rd_en;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data      = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.state     = ~empty;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a behavioural baud generator and line driver.
module tb_uart_rx;
    localparam int unsigned BIT  = 16;
    localparam int unsigned HALF = BIT / 2;

    logic clk = 1'b0;
    logic RSTn;
    logic RXD;
    logic clk_uart;
    logic bps_en;
    logic tx_busy = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int unsigned bcnt;

    uart_rx_if bus ();

    uart_rx #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .RSTn     (RSTn),
        .RXD      (RXD),
        .clk_uart (clk_uart),
        .bps_en   (bps_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Baud generator: first tick half a bit after enable, then every bit.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            bcnt     <= HALF;
            clk_uart <= 1'b0;
        end else if (!bps_en) begin
            bcnt     <= HALF;
            clk_uart <= 1'b0;
        end else if (bcnt == BIT - 1) begin
            bcnt     <= 0;
            clk_uart <= 1'b1;
        end else begin
            bcnt     <= bcnt + 1;
            clk_uart <= 1'b0;
        end
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) RXD = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (BIT) @(negedge clk);
        end
        RXD = stop_bit;
        repeat (BIT) @(negedge clk);
        RXD = 1'b1;
    endtask

    // Returns at the negedge inside the n-th baud tick cycle.
    task automatic wait_ticks(input int n);
        int cnt    = 0;
        int budget = n * int'(BIT) * 2 + 64;
        while (cnt < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (clk_uart && bps_en) cnt++;
        end
        checks++;
        assert (cnt == n) else begin
            errors++;
            $error("FAIL tick_wait: observed=%0d expected=%0d", cnt, n);
        end
    endtask

    task automatic wait_tx;
        int budget = 40 * int'(BIT) * 12;
        while (tx_busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        assert (!tx_busy) else begin
            errors++;
            $error("FAIL tx_wait: observed=busy expected=idle");
        end
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pop_once;
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0;
        RXD = 1'b1;
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_state", bus.state, 1'b0);
        chk8("rst_data", bus.data, 8'h00);
        chk1("rst_bps_en", bps_en, 1'b0);
        chk1("rst_frame_err", bus.frame_err, 1'b0);
        chk1("rst_overrun", bus.overrun, 1'b0);
        RSTn = 1'b1;
        repeat (4) @(negedge clk);

        // Single good byte
        fork begin tx_busy = 1'b1; send_frame(8'hA5, 1'b1); tx_busy = 1'b0; end join_none
        wait_ticks(10);
        chk1("a5_state_at_tick", bus.state, 1'b0);
        @(negedge clk);
        chk1("a5_state", bus.state, 1'b1);
        chk8("a5_data", bus.data, 8'hA5);
        chk1("a5_frame_err", bus.frame_err, 1'b0);
        chk1("a5_overrun", bus.overrun, 1'b0);
        chk1("a5_bps_off", bps_en, 1'b0);
        wait_tx();
        pop_once();
        chk1("a5_popped", bus.state, 1'b0);

        // Short low glitch: false start
        @(negedge clk) RXD = 1'b0;
        repeat (4) @(negedge clk);
        RXD = 1'b1;
        for (int i = 0; i < 20 && !bps_en; i++) @(negedge clk);
        chk1("glitch_bps_on", bps_en, 1'b1);
        wait_ticks(1);
        @(negedge clk);
        chk1("glitch_bps_off", bps_en, 1'b0);
        chk1("glitch_state", bus.state, 1'b0);
        chk1("glitch_frame_err", bus.frame_err, 1'b0);
        chk1("glitch_overrun", bus.overrun, 1'b0);
        repeat (BIT) @(negedge clk);

        // Bad stop bit, then a good frame
        fork begin tx_busy = 1'b1; send_frame(8'h3C, 1'b0); tx_busy = 1'b0; end join_none
        wait_ticks(10);
        chk1("ferr_idle_at_tick", bus.frame_err, 1'b0);
        @(negedge clk);
        chk1("ferr_pulse", bus.frame_err, 1'b1);
        chk1("ferr_state", bus.state, 1'b0);
        chk1("ferr_overrun", bus.overrun, 1'b0);
        @(negedge clk);
        chk1("ferr_one_cycle", bus.frame_err, 1'b0);
        wait_tx();
        fork begin tx_busy = 1'b1; send_frame(8'h11, 1'b1); tx_busy = 1'b0; end join_none
        wait_ticks(10);
        @(negedge clk);
        chk1("after_ferr_state", bus.state, 1'b1);
        chk8("after_ferr_data", bus.data, 8'h11);
        wait_tx();
        pop_once();
        chk1("after_ferr_popped", bus.state, 1'b0);

        // 17 back-to-back bytes into a 16-deep FIFO
        fork begin
            tx_busy = 1'b1;
            for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
            tx_busy = 1'b0;
        end join_none
        for (int i = 0; i < 17; i++) begin
            wait_ticks(10);
            @(negedge clk);
            chk1($sformatf("fill_overrun_%0d", i), bus.overrun, (i == 16));
            chk1($sformatf("fill_state_%0d", i), bus.state, 1'b1);
        end
        @(negedge clk);
        chk1("overrun_one_cycle", bus.overrun, 1'b0);
        wait_tx();
        for (int i = 0; i < 16; i++) begin
            chk8($sformatf("drain_%0d", i), bus.data, 8'(i));
            pop_once();
        end
        chk1("drain_empty", bus.state, 1'b0);

        // Full FIFO with a pop in the stop-tick cycle of 8'h77
        fork begin
            tx_busy = 1'b1;
            for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
            send_frame(8'h77, 1'b1);
            tx_busy = 1'b0;
        end join_none
        wait_ticks(160);
        wait_ticks(10);
        chk8("full_head_before", bus.data, 8'h20);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk1("full_pop_no_overrun", bus.overrun, 1'b0);
        chk1("full_pop_state", bus.state, 1'b1);
        wait_tx();
        for (int i = 0; i < 15; i++) begin
            chk8($sformatf("full_drain_%0d", i), bus.data, 8'h21 + 8'(i));
            pop_once();
        end
        chk8("full_last_77", bus.data, 8'h77);
        pop_once();
        chk1("full_drained", bus.state, 1'b0);

        // Reset in the middle of a frame
        fork begin tx_busy = 1'b1; send_frame(8'h5A, 1'b1); tx_busy = 1'b0; end join_none
        wait_ticks(10);
        @(negedge clk);
        chk1("pre_rst_state", bus.state, 1'b1);
        wait_tx();
        fork begin tx_busy = 1'b1; send_frame(8'hC3, 1'b1); tx_busy = 1'b0; end join_none
        wait_ticks(6);
        RSTn = 1'b0;
        #1;
        chk1("midrst_bps_en", bps_en, 1'b0);
        chk1("midrst_state", bus.state, 1'b0);
        chk8("midrst_data", bus.data, 8'h00);
        wait_tx();
        RSTn = 1'b1;
        repeat (4) @(negedge clk);
        chk1("postrst_state", bus.state, 1'b0);
        fork begin tx_busy = 1'b1; send_frame(8'hC3, 1'b1); tx_busy = 1'b0; end join_none
        wait_ticks(10);
        @(negedge clk);
        chk1("postrst_rx_state", bus.state, 1'b1);
        chk8("postrst_rx_data", bus.data, 8'hC3);
        wait_tx();
        pop_once();
        chk1("postrst_popped", bus.state, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
